// File: rtl/store_router_pkg.sv
// Shared types and constants for the CPU store path: size codes, slave targets,
// the AdES exception code and the default memory map.
package store_router_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    TGT_DM   = 3'd0,
    TGT_TC0  = 3'd1,
    TGT_TC1  = 3'd2,
    TGT_IG   = 3'd3,
    TGT_NONE = 3'd4
  } target_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  localparam logic [4:0] EXC_ADES     = 5'd5;
  localparam logic [3:0] TC_COUNT_OFS = 4'h8;

  // Timers span three words; the interrupt generator is a single word.
  localparam logic [31:0] TC_SPAN = 32'd12;
  localparam logic [31:0] IG_SPAN = 32'd4;

  localparam logic [31:0] DEF_DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_DM_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] DEF_TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEF_TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] DEF_IG_BASE  = 32'h0000_7F20;

endpackage

// File: rtl/store_router_lane_steer.sv
// Combinational byte-lane steering for CPU stores: replicates byte/half data
// across lanes, builds byte enables and flags misalignment or a reserved size.
module store_lane_steer
  import store_router_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  byteen,
  output logic        misaligned,
  output logic        bad_size
);

  always_comb begin
    lane_wdata = wdata;
    byteen     = 4'b1111;
    misaligned = 1'b0;
    bad_size   = 1'b0;
    case (size)
      SZ_BYTE: begin
        lane_wdata = {4{wdata[7:0]}};
        byteen     = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        lane_wdata = {2{wdata[15:0]}};
        byteen     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        byteen   = 4'b0000;
        bad_size = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_router.sv
// CPU store router: decodes the target slave, steers data into byte lanes and
// holds one store until the slave accepts it; illegal stores raise AdES.
module store_router
  import store_router_pkg::*;
#(
  parameter logic [31:0] DM_BASE  = DEF_DM_BASE,
  parameter logic [31:0] DM_LIMIT = DEF_DM_LIMIT,
  parameter logic [31:0] TC0_BASE = DEF_TC0_BASE,
  parameter logic [31:0] TC1_BASE = DEF_TC1_BASE,
  parameter logic [31:0] IG_BASE  = DEF_IG_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_byteen,
  output logic        dm_valid,
  input  logic        dm_ready,
  output logic        tc0_valid,
  input  logic        tc0_ready,
  output logic        tc1_valid,
  input  logic        tc1_ready,
  output logic        ig_valid,
  input  logic        ig_ready,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_badvaddr
);

  buf_state_t  state;
  target_t     tgt;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_byteen;
  logic        misaligned;
  logic        bad_size;
  logic [31:0] dm_ofs;
  logic [31:0] tc0_ofs;
  logic [31:0] tc1_ofs;
  logic [31:0] ig_ofs;
  logic        count_hit;
  logic        req_err;
  logic        sel_ready;
  logic        accept;
  logic        drain;

  store_lane_steer u_steer (
    .size       (req_size),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .lane_wdata (lane_wdata),
    .byteen     (lane_byteen),
    .misaligned (misaligned),
    .bad_size   (bad_size)
  );

  // Offsets wrap below each base, so one unsigned compare checks both ends.
  assign dm_ofs  = req_addr - DM_BASE;
  assign tc0_ofs = req_addr - TC0_BASE;
  assign tc1_ofs = req_addr - TC1_BASE;
  assign ig_ofs  = req_addr - IG_BASE;

  always_comb begin
    tgt       = TGT_NONE;
    count_hit = 1'b0;
    if (dm_ofs <= (DM_LIMIT - DM_BASE)) begin
      tgt = TGT_DM;
    end else if (tc0_ofs < TC_SPAN) begin
      tgt       = TGT_TC0;
      count_hit = ((tc0_ofs[3:0] & 4'hC) == TC_COUNT_OFS);
    end else if (tc1_ofs < TC_SPAN) begin
      tgt       = TGT_TC1;
      count_hit = ((tc1_ofs[3:0] & 4'hC) == TC_COUNT_OFS);
    end else if (ig_ofs < IG_SPAN) begin
      tgt = TGT_IG;
    end
  end

  // Peripherals only take full-word writes; the timer Count word is read-only.
  always_comb begin
    req_err = bad_size || misaligned || (tgt == TGT_NONE) || count_hit;
    if ((tgt != TGT_DM) && (req_size != SZ_WORD)) begin
      req_err = 1'b1;
    end
  end

  assign sel_ready = (dm_valid & dm_ready) | (tc0_valid & tc0_ready)
                   | (tc1_valid & tc1_ready) | (ig_valid & ig_ready);
  assign drain     = (state == ST_FULL) && sel_ready;
  assign req_ready = (state == ST_EMPTY) || sel_ready;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_EMPTY;
      dm_valid     <= 1'b0;
      tc0_valid    <= 1'b0;
      tc1_valid    <= 1'b0;
      ig_valid     <= 1'b0;
      out_addr     <= '0;
      out_wdata    <= '0;
      out_byteen   <= '0;
      exc_valid    <= 1'b0;
      exc_code     <= '0;
      exc_badvaddr <= '0;
    end else begin
      exc_valid <= 1'b0;
      exc_code  <= '0;
      if (accept && !req_err) begin
        state      <= ST_FULL;
        dm_valid   <= (tgt == TGT_DM);
        tc0_valid  <= (tgt == TGT_TC0);
        tc1_valid  <= (tgt == TGT_TC1);
        ig_valid   <= (tgt == TGT_IG);
        out_addr   <= {req_addr[31:2], 2'b00};
        out_wdata  <= lane_wdata;
        out_byteen <= lane_byteen;
      end else if (drain) begin
        state     <= ST_EMPTY;
        dm_valid  <= 1'b0;
        tc0_valid <= 1'b0;
        tc1_valid <= 1'b0;
        ig_valid  <= 1'b0;
      end
      if (accept && req_err) begin
        exc_valid    <= 1'b1;
        exc_code     <= EXC_ADES;
        exc_badvaddr <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_store_router.sv
// Randomized and directed bench for store_router, checked against a
// transaction-level model of the store buffer and address map.
module tb_store_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_byteen;
  logic        dm_valid, dm_ready;
  logic        tc0_valid, tc0_ready;
  logic        tc1_valid, tc1_ready;
  logic        ig_valid, ig_ready;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  int checks = 0;
  int errors = 0;

  // Model state: one buffered store (target 0..3 = dm/tc0/tc1/ig) plus exception.
  bit          m_full;
  int          m_tgt;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_byteen;
  bit          m_exc;
  logic [31:0] m_bad;

  store_router dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata),
    .out_byteen   (out_byteen),
    .dm_valid     (dm_valid),
    .dm_ready     (dm_ready),
    .tc0_valid    (tc0_valid),
    .tc0_ready    (tc0_ready),
    .tc1_valid    (tc1_valid),
    .tc1_ready    (tc1_ready),
    .ig_valid     (ig_valid),
    .ig_ready     (ig_ready),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_badvaddr (exc_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Address map and legality rules, written directly from the memory map.
  function automatic void classify(input logic [1:0] sz, input logic [31:0] a,
                                   output int tgt, output bit legal);
    if (a <= 32'h2FFF) tgt = 0;
    else if (a >= 32'h7F00 && a <= 32'h7F0B) tgt = 1;
    else if (a >= 32'h7F10 && a <= 32'h7F1B) tgt = 2;
    else if (a >= 32'h7F20 && a <= 32'h7F23) tgt = 3;
    else tgt = -1;
    legal = 1;
    if (sz == 2'b11) legal = 0;
    if (sz == 2'b01 && (a % 2) != 0) legal = 0;
    if (sz == 2'b10 && (a % 4) != 0) legal = 0;
    if (tgt < 0) legal = 0;
    if (tgt >= 1 && sz != 2'b10) legal = 0;
    if ((tgt == 1 || tgt == 2) && (a % 16) >= 8) legal = 0;
  endfunction

  function automatic void lanes(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] w, output logic [3:0] en);
    case (sz)
      2'b00: begin w = {4{d[7:0]}};  en = 4'(1 << (a % 4)); end
      2'b01: begin w = {2{d[15:0]}}; en = ((a % 4) >= 2) ? 4'b1100 : 4'b0011; end
      default: begin w = d; en = 4'b1111; end
    endcase
  endfunction

  function automatic logic [3:0] ready_vec();
    return {ig_ready, tc1_ready, tc0_ready, dm_ready};
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic applyStimulus(input logic v, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] rdy);
    int tgt;
    bit legal;
    bit sel_rdy, exp_ready, acc;
    logic [31:0] w;
    logic [3:0] en;
    @(negedge clk);
    req_valid = v; req_size = sz; req_addr = a; req_wdata = d;
    {ig_ready, tc1_ready, tc0_ready, dm_ready} = rdy;
    #1;
    checkOutput("dm_valid",  32'(dm_valid),  32'(m_full && m_tgt == 0));
    checkOutput("tc0_valid", 32'(tc0_valid), 32'(m_full && m_tgt == 1));
    checkOutput("tc1_valid", 32'(tc1_valid), 32'(m_full && m_tgt == 2));
    checkOutput("ig_valid",  32'(ig_valid),  32'(m_full && m_tgt == 3));
    checkOutput("exc_valid", 32'(exc_valid), 32'(m_exc));
    checkOutput("exc_code",  32'(exc_code),  m_exc ? 32'd5 : 32'd0);
    checkOutput("badvaddr",  exc_badvaddr,   m_bad);
    if (m_full) begin
      checkOutput("out_addr",   out_addr,         m_addr);
      checkOutput("out_wdata",  out_wdata,        m_wdata);
      checkOutput("out_byteen", 32'(out_byteen),  32'(m_byteen));
    end
    sel_rdy   = m_full && rdy[m_tgt];
    exp_ready = !m_full || sel_rdy;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = v && exp_ready;
    classify(sz, a, tgt, legal);
    lanes(sz, a, d, w, en);
    @(posedge clk);
    m_exc = 0;
    if (acc && legal) begin
      m_full = 1; m_tgt = tgt;
      m_addr = a & 32'hFFFF_FFFC; m_wdata = w; m_byteen = en;
    end else if (sel_rdy) begin
      m_full = 0;
    end
    if (acc && !legal) begin
      m_exc = 1; m_bad = a;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    m_full = 0; m_exc = 0; m_bad = '0;
    #2;
    checkOutput("rst_dm_valid", 32'(dm_valid), 32'd0);
    checkOutput("rst_exc_valid", 32'(exc_valid), 32'd0);
    checkOutput("rst_badvaddr", exc_badvaddr, 32'd0);
    checkOutput("rst_out_addr", out_addr, 32'd0);
    checkOutput("rst_out_wdata", out_wdata, 32'd0);
    checkOutput("rst_out_byteen", 32'(out_byteen), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b1; req_valid = 0; req_size = 0; req_addr = 0; req_wdata = 0;
    {ig_ready, tc1_ready, tc0_ready, dm_ready} = 4'b0000;
    doReset();

    applyStimulus(1, 2'b00, 32'h13, 32'h1234_56AB, 4'b1111);
    #2;
    checkOutput("tp_sb_valid",  32'(dm_valid),   32'd1);
    checkOutput("tp_sb_addr",   out_addr,        32'h10);
    checkOutput("tp_sb_byteen", 32'(out_byteen), 32'h8);
    checkOutput("tp_sb_wdata",  out_wdata,       32'hABAB_ABAB);

    applyStimulus(1, 2'b01, 32'h22, 32'h0000_BEEF, 4'b1111);
    #2;
    checkOutput("tp_sh_byteen", 32'(out_byteen), 32'hC);
    checkOutput("tp_sh_wdata",  out_wdata,       32'hBEEF_BEEF);
    checkOutput("tp_sh_addr",   out_addr,        32'h20);
    applyStimulus(1, 2'b01, 32'h21, 32'h0, 4'b1111);
    #2;
    checkOutput("tp_sh_exc",  32'(exc_valid), 32'd1);
    checkOutput("tp_sh_code", 32'(exc_code),  32'd5);
    checkOutput("tp_sh_bad",  exc_badvaddr,   32'h21);
    checkOutput("tp_sh_noval", 32'({dm_valid, tc0_valid, tc1_valid, ig_valid}), 32'd0);

    applyStimulus(1, 2'b10, 32'h7F04, 32'h64, 4'b1111);
    #2 checkOutput("tp_tc0", 32'(tc0_valid), 32'd1);
    applyStimulus(1, 2'b10, 32'h7F14, 32'h1, 4'b1111);
    #2 checkOutput("tp_tc1", 32'({tc0_valid, tc1_valid}), 32'b01);
    applyStimulus(1, 2'b10, 32'h7F08, 32'h5, 4'b1111);
    #2 checkOutput("tp_count_bad", exc_badvaddr, 32'h7F08);
    applyStimulus(1, 2'b00, 32'h7F20, 32'h5, 4'b1111);
    #2 checkOutput("tp_ig_sb_exc", 32'(exc_valid), 32'd1);

    // Backpressure: second store waits while the first is held.
    applyStimulus(1, 2'b10, 32'h100, 32'hAAAA_0001, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'b10, 32'h104, 32'hAAAA_0002, 4'b1110);
      #2 checkOutput("bp_hold_addr", out_addr, 32'h100);
    end
    applyStimulus(1, 2'b10, 32'h104, 32'hAAAA_0002, 4'b1111);
    #2 checkOutput("bp_next_addr", out_addr, 32'h104);
    applyStimulus(0, 2'b10, 32'h0, 32'h0, 4'b1111);

    applyStimulus(1, 2'b10, 32'h3000, 32'h0, 4'b1111);
    #2 checkOutput("tp_limit_exc", 32'(exc_valid), 32'd1);
    applyStimulus(1, 2'b11, 32'h40, 32'h0, 4'b1111);
    #2 checkOutput("tp_size_exc", 32'(exc_valid), 32'd1);
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 4'b1111);

    applyStimulus(1, 2'b10, 32'h200, 32'h1, 4'b0000);
    applyStimulus(1, 2'b10, 32'h3001, 32'h1, 4'b0000);
    doReset();

    for (int n = 0; n < 3000; n++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, 32'h2FFF));
        2:    a = 32'h7F00 + 32'($urandom_range(0, 47));
        3:    a = 32'h2FF0 + 32'($urandom_range(0, 31));
        4:    a = $urandom;
        default: a = 32'h7F00 + 32'($urandom_range(0, 8) * 4);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if (n % 500 == 499) doReset();
      applyStimulus(1'($urandom_range(0, 3) != 0), sz, a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_router.md
Name: store_router

Overview:
- Write-side counterpart of the load-path byte/half extraction muxes and bus-bridge read multiplexer.
- Accepts one CPU store per cycle as size, byte address and raw register data.
- Steers the data into byte lanes, generates byte enables and decodes the target among DM, Timer0, Timer1 and the interrupt generator.
- Holds the request in a one-entry output buffer until the target acknowledges; illegal stores raise AdES instead of reaching any slave.

Parameters:
- DM_BASE, 32'h0000_0000, first DM byte address.
- DM_LIMIT, 32'h0000_2FFF, last DM byte address (inclusive).
- TC0_BASE, 32'h0000_7F00, Timer0 base; registers at offsets 0x0/0x4/0x8.
- TC1_BASE, 32'h0000_7F10, Timer1 base; same layout as Timer0.
- IG_BASE, 32'h0000_7F20, interrupt-generator base; single word.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_addr  in  32  byte address
- req_wdata  in  32  raw rt value; low bits significant for byte/half
- out_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- out_wdata  out  32  lane-steered data
- out_byteen  out  4  byte enables, bit i = lane i
- dm_valid / dm_ready  out / in  1 / 1  DM handshake
- tc0_valid / tc0_ready  out / in  1 / 1  Timer0 handshake
- tc1_valid / tc1_ready  out / in  1 / 1  Timer1 handshake
- ig_valid / ig_ready  out / in  1 / 1  interrupt-generator handshake
- exc_valid  out  1  one-cycle AdES pulse
- exc_code  out  5  5'd5 when exc_valid, else 0
- exc_badvaddr  out  32  address of the last faulting store

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - Buffer empty; all *_valid = 0; exc_valid = 0.
  - exc_badvaddr = 0; out_addr, out_wdata and out_byteen = 0.
  - Reset mid-transfer drops the buffered store silently.
- Lane steering:
  - byte: wdata = {4{wdata[7:0]}}, byteen = 4'b0001 << addr[1:0].
  - half: wdata = {2{wdata[15:0]}}, byteen = addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata unchanged, byteen = 4'b1111.
- Error conditions; any one gives AdES:
  - size = 11.
  - half with addr[0] = 1.
  - word with addr[1:0] != 0.
  - Address outside all four regions.
  - Byte or half store to any TC0/TC1/IG address.
  - Any store to timer offset 0x8 (Count, read-only).
  - Timer region is base..base+0xB; IG is exactly IG_BASE..IG_BASE+3.
- Buffer and handshake:
  - State is EMPTY or FULL.
  - A FULL buffer asserts exactly one *_valid, selected by the latched target.
  - out_* stay stable while valid && !ready.
  - req_ready = EMPTY || (selected slave ready). Errors use the same ready rule.
  - On acceptance of a legal request the buffer loads the next cycle (latency 1: accept at edge N, slave valid visible after edge N).
  - Drain and accept in the same cycle: the buffer reloads, which gives back-to-back throughput of 1 store/cycle while the slave is ready.
  - Drain with no new request: goes to EMPTY and valid drops.
- Error acceptance:
  - The request is consumed and never enters the buffer.
  - If the buffer was FULL and drained that cycle, it goes EMPTY.
  - exc_valid = 1 and exc_code = 5 for the single cycle after acceptance; exc_badvaddr takes the full unaligned req_addr.
  - Back-to-back errors produce consecutive pulses, with badvaddr updated each time.
- Ordering: strictly in order, with no reordering between slaves.
- Slave ready ignored: a slave's ready is don't-care while its valid is low.

Decomposition:
- Package store_router_pkg:
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - Target enum TGT_DM/TGT_TC0/TGT_TC1/TGT_IG/TGT_NONE.
  - EXC_ADES = 5'd5.
  - Timer offset constant TC_COUNT_OFS = 4'h8.
  - Default address-map constants.
- Sub-module store_lane_steer: combinational size+addr[1:0]+wdata -> wdata/byteen/misaligned.
- Top-level holds address decode, buffer FSM and exception register.

Test Plan:
- sb addr 0x0000_0013, wdata 0x1234_56AB, dm_ready=1 -> next cycle dm_valid=1, out_addr 0x10, out_byteen 4'b1000, out_wdata 0xABAB_ABAB.
- sh addr 0x0000_0022, wdata 0x0000_BEEF -> out_byteen 4'b1100, out_wdata 0xBEEF_BEEF, out_addr 0x20; sh addr 0x21 -> exc_valid pulse, code 5, badvaddr 0x21, no *_valid.
- sw 0x7F04 data 0x64 then sw 0x7F14 data 0x1, both slaves ready -> tc0_valid one cycle then tc1_valid next cycle; sw 0x7F08 -> AdES, badvaddr 0x7F08; sb 0x7F20 -> AdES.
- Backpressure:
  - Stimulus: two DM stores with dm_ready low for 3 cycles.
  - First store: held with out_* stable.
  - Second store: req_ready=0 until dm_ready rises.
  - Drain: then 1/cycle.
- sw 0x0000_3000 (past DM_LIMIT) and size=11 -> AdES each; exc_valid pulses in consecutive cycles.
- reset asserted while buffer FULL and dm_ready=0 -> next cycle dm_valid=0, req_ready=1, exc_badvaddr=0.
